key_event_gen: RTL

//  Converts the raw 8-bit USB HID keycode into one-cycle game-action pulses.

---
 rtl/key_event_if.sv | 33 +++
 rtl/key_event_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event_if.sv
// ---------------------------------------------------------------------------
// key_event_if
// Bundles the keyboard/VGA inputs and the game-action outputs of
// key_event_gen into one port.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface key_event_if;
    logic       VGA_VS;
    logic [7:0] keycode;
    logic       accept;
    logic       frame_tick;
    logic       move_left;
    logic       move_right;
    logic       rotate;
    logic       soft_drop;
    logic       hard_drop;

    // Stimulus side: keyboard, VGA controller and game FSM
    modport master (
        output VGA_VS, keycode, accept,
        input  frame_tick, move_left, move_right, rotate, soft_drop, hard_drop
    );

    // Key event generator side
    modport slave (
        input  VGA_VS, keycode, accept,
        output frame_tick, move_left, move_right, rotate, soft_drop, hard_drop
    );
endinterface

`default_nettype wire

// File: rtl/key_event_gen.sv
// ---------------------------------------------------------------------------
// key_event_gen
// Turns the raw HID keycode into one-cycle game-action pulses with DAS and
// auto-repeat for left/right, repeat for soft drop, and single-shot rotate
// and hard drop. Also produces a frame tick from VGA vertical sync.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_event_gen #(
    parameter int DAS_FRAMES  = 10,
    parameter int ARR_FRAMES  = 2,
    parameter int SOFT_FRAMES = 2
) (
    input  wire logic  Clk,
    input  wire logic  reset,
    key_event_if.slave bus
);

    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_ROT   = 8'h52;
    localparam logic [7:0] KEY_SOFT  = 8'h51;
    localparam logic [7:0] KEY_HARD  = 8'h2C;

    localparam logic [5:0] DAS_C  = 6'(DAS_FRAMES);
    localparam logic [5:0] ARR_C  = 6'(ARR_FRAMES);
    localparam logic [5:0] SOFT_C = 6'(SOFT_FRAMES);

    // Timing counters are 6 bits wide, so only 1..63 frames can be expressed.
    generate
        if (DAS_FRAMES < 1 || DAS_FRAMES > 63 ||
            ARR_FRAMES < 1 || ARR_FRAMES > 63 ||
            SOFT_FRAMES < 1 || SOFT_FRAMES > 63) begin : g_bad_param
            $error("key_event_gen: frame parameters must be in 1..63");
        end
    endgenerate

    typedef enum logic [1:0] {
        H_IDLE   = 2'd0,
        H_DAS    = 2'd1,
        H_REPEAT = 2'd2
    } hstate_t;

    // Registered state
    logic       vs_s0, vs_s1, vs_d;
    logic [7:0] key_q, key_prev;
    hstate_t    hstate;
    logic [7:0] dir;
    logic [5:0] cnt;
    logic [5:0] scnt;
    logic       s_active;
    logic       hd_ready;
    logic       frame_tick_q, left_q, right_q, rot_q, soft_q, hard_q;

    // Next-state values
    hstate_t    hstate_n;
    logic [7:0] dir_n;
    logic [5:0] cnt_n;
    logic [5:0] scnt_n;
    logic       s_active_n;
    logic       hd_ready_n;
    logic       left_n, right_n, rot_n, soft_n, hard_n;

    logic       tick;
    logic       h_press;

    assign tick    = vs_s1 & ~vs_d;
    assign h_press = (key_q == KEY_LEFT || key_q == KEY_RIGHT) && (key_prev != key_q);

    // Register VS synchroniser, key pipeline, FSM state, counters and pulses
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            vs_s0        <= 1'b0;
            vs_s1        <= 1'b0;
            vs_d         <= 1'b0;
            key_q        <= 8'h00;
            key_prev     <= 8'h00;
            hstate       <= H_IDLE;
            dir          <= 8'h00;
            cnt          <= 6'd0;
            scnt         <= 6'd0;
            s_active     <= 1'b0;
            hd_ready     <= 1'b1;
            frame_tick_q <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            rot_q        <= 1'b0;
            soft_q       <= 1'b0;
            hard_q       <= 1'b0;
        end else begin
            vs_s0        <= bus.VGA_VS;
            vs_s1        <= vs_s0;
            vs_d         <= vs_s1;
            key_q        <= bus.keycode;
            key_prev     <= key_q;
            hstate       <= hstate_n;
            dir          <= dir_n;
            cnt          <= cnt_n;
            scnt         <= scnt_n;
            s_active     <= s_active_n;
            hd_ready     <= hd_ready_n;
            frame_tick_q <= tick;
            left_q       <= left_n;
            right_q      <= right_n;
            rot_q        <= rot_n;
            soft_q       <= soft_n;
            hard_q       <= hard_n;
        end
    end

    // Horizontal DAS/ARR machine: a changed key always drops back to idle and
    // is re-evaluated as a press in the same cycle, so press beats a tick.
    always_comb begin
        hstate_n = hstate;
        dir_n    = dir;
        cnt_n    = cnt;
        left_n   = 1'b0;
        right_n  = 1'b0;
        if (!bus.accept) begin
            hstate_n = H_IDLE;
            cnt_n    = 6'd0;
        end else if (hstate == H_IDLE || key_q != dir) begin
            hstate_n = H_IDLE;
            cnt_n    = 6'd0;
            if (h_press) begin
                dir_n    = key_q;
                hstate_n = H_DAS;
                left_n   = (key_q == KEY_LEFT);
                right_n  = (key_q == KEY_RIGHT);
            end
        end else if (tick) begin
            case (hstate)
                H_DAS: begin
                    if (cnt + 6'd1 == DAS_C) begin
                        left_n   = (dir == KEY_LEFT);
                        right_n  = (dir == KEY_RIGHT);
                        cnt_n    = 6'd0;
                        hstate_n = H_REPEAT;
                    end else begin
                        cnt_n = cnt + 6'd1;
                    end
                end
                H_REPEAT: begin
                    if (cnt + 6'd1 == ARR_C) begin
                        left_n  = (dir == KEY_LEFT);
                        right_n = (dir == KEY_RIGHT);
                        cnt_n   = 6'd0;
                    end else begin
                        cnt_n = cnt + 6'd1;
                    end
                end
                default: begin
                    hstate_n = H_IDLE;
                    cnt_n    = 6'd0;
                end
            endcase
        end
    end

    // Soft drop repeats only after a fresh press seen while accept was high
    always_comb begin
        scnt_n     = scnt;
        s_active_n = s_active;
        soft_n     = 1'b0;
        if (!bus.accept || key_q != KEY_SOFT) begin
            scnt_n     = 6'd0;
            s_active_n = 1'b0;
        end else if (key_prev != KEY_SOFT) begin
            soft_n     = 1'b1;
            s_active_n = 1'b1;
            scnt_n     = 6'd0;
        end else if (s_active && tick) begin
            if (scnt + 6'd1 == SOFT_C) begin
                soft_n = 1'b1;
                scnt_n = 6'd0;
            end else begin
                scnt_n = scnt + 6'd1;
            end
        end
    end

    // Rotate fires on the press edge; hard drop is armed again only by a
    // cycle without the key, regardless of accept
    always_comb begin
        rot_n      = bus.accept && (key_q == KEY_ROT) && (key_prev != KEY_ROT);
        hard_n     = 1'b0;
        hd_ready_n = hd_ready;
        if (key_q == KEY_HARD) begin
            if (hd_ready) begin
                hard_n     = bus.accept;
                hd_ready_n = 1'b0;
            end
        end else begin
            hd_ready_n = 1'b1;
        end
    end

    assign bus.frame_tick = frame_tick_q;
    assign bus.move_left  = left_q;
    assign bus.move_right = right_q;
    assign bus.rotate     = rot_q;
    assign bus.soft_drop  = soft_q;
    assign bus.hard_drop  = hard_q;

endmodule

`default_nettype wire
